// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default operand width and the
// multiplier's sequencing states.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/n_bit_adder.sv
// Ripple-carry N-bit adder: sum = a + b, with the final carry brought out
// so callers can extend the result by one bit.
module n_bit_adder #(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic [N-1:0] sum,
    output logic         carry_out
);

    always_comb begin
        logic [N:0] c;
        c   = '0;
        sum = '0;
        for (int i = 0; i < N; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        carry_out = c[N];
    end

endmodule

// File: rtl/shift_add_multiplier.sv
// Multi-cycle unsigned NxN->2N multiplier: one add-and-shift step per clock
// using the shared ripple-carry adder, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; product holds the last result
// RUN   | N add-and-shift steps, busy high
// DONE  | one-cycle done pulse, product valid
module shift_add_multiplier
    import alu_pkg::*;
#(
    parameter int N = ALU_WIDTH
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product
);

    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(N - 1);

    mul_state_t      state;
    logic [N-1:0]    m_reg;
    logic [2*N-1:0]  p_reg;
    logic [CW-1:0]   cnt;
    logic [N-1:0]    sum;
    logic            carry;

    n_bit_adder #(.N(N)) u_adder (
        .a         (p_reg[2*N-1:N]),
        .b         (m_reg),
        .sum       (sum),
        .carry_out (carry)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            m_reg <= '0;
            p_reg <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= a;
                        p_reg <= {{N{1'b0}}, b};
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    // Adder carry lands in the top bit so (2^N-1)^2 cannot overflow.
                    if (p_reg[0])
                        p_reg <= {carry, sum, p_reg[N-1:1]};
                    else
                        p_reg <= {1'b0, p_reg[2*N-1:N], p_reg[N-1:1]};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign product = p_reg;

endmodule
